calc_sequencer: RTL and testbench

Sequential front-end for the combinational calculator datapath in the tt_um top.
- Collects operand A, operand B and opcode as successive bytes from the shared 8-bit input bus, qualified by a host strobe.
- Holds the assembled operands stable to the datapath for a fixed execution window.
- Captures the result and error flag and presents them until the next operation starts.

---
 rtl/calc_pkg.sv | 19 +
 rtl/calc_sequencer_if.sv | 30 +++
 rtl/calc_strobe_sync.sv | 41 ++++
 rtl/calc_sequencer.sv | 145 ++++++++++++++
 tb/tb_calc_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared encodings and defaults for the calculator sequencer, its datapath and bench.
// Pure declarations: no logic, no latency, no flow control.
package calc_pkg;

    localparam int CALC_DATA_W = 8;
    localparam int CALC_OP_W   = 3;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CALC_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [CALC_OP_W-1:0] OP_SUB = 3'd1;

endpackage

// File: rtl/calc_sequencer_if.sv
// Operand/result bundle between the sequencer (master) and the combinational datapath (slave).
// Master drives registered operands; the slave returns result and error combinationally.
interface calc_sequencer_if
    import calc_pkg::*;
#(
    parameter int DATA_W = CALC_DATA_W,
    parameter int OP_W   = CALC_OP_W
);
    logic [DATA_W-1:0] calc_a;
    logic [DATA_W-1:0] calc_b;
    logic [OP_W-1:0]   calc_op;
    logic [DATA_W-1:0] calc_result;
    logic              calc_err;

    modport master (
        output calc_a,
        output calc_b,
        output calc_op,
        input  calc_result,
        input  calc_err
    );

    modport slave (
        input  calc_a,
        input  calc_b,
        input  calc_op,
        output calc_result,
        output calc_err
    );
endinterface

// File: rtl/calc_strobe_sync.sv
// Synchronises the asynchronous host strobe and emits one pulse per synced rising edge.
// Latency SYNC_STAGES cycles from strobe rise to pulse; no backpressure.
module calc_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async_in,
    output logic o_pulse_out
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_edge;
    logic                   r_armed;
    logic                   w_synced;
    logic                   w_chain_full;

    assign w_synced     = r_sync[SYNC_STAGES-1];
    assign w_chain_full = r_fill[SYNC_STAGES-1];

    // Reset zeros in the chain are not a real low level: only arm once a sampled low has
    // propagated, so a strobe already high at reset release cannot produce a pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_edge  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async_in};
            r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_edge  <= w_synced;
            if (w_chain_full && !w_synced) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_pulse_out = w_synced & ~r_edge & r_armed;

endmodule

// File: rtl/calc_sequencer.sv
// Collects A, B and opcode bytes from a strobed host bus, holds them for EXEC_LAT cycles, captures the result.
// Result valid EXEC_LAT+1 cycles after the opcode pulse; strobes arriving during execution are dropped.
// Optional CALC_SEQ_ACC_EN: a byte after completion becomes B with the previous result as A.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W      = CALC_DATA_W,
    parameter int OP_W        = CALC_OP_W,
    parameter int EXEC_LAT    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_strobe,
    input  logic              i_clear,
    calc_sequencer_if.master  dp,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_valid,
    output logic              o_err,
    output logic              o_busy,
    output logic [2:0]        o_state
);
    localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    logic              w_pulse;
    state_t            r_state, w_state;
    logic [DATA_W-1:0] r_a, w_a;
    logic [DATA_W-1:0] r_b, w_b;
    logic [OP_W-1:0]   r_op, w_op;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [DATA_W-1:0] r_result, w_result;
    logic              r_err, w_err;
    logic              r_valid, w_valid;

    calc_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_async_in  (i_in_strobe),
        .o_pulse_out (w_pulse)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_a      <= w_a;
            r_b      <= w_b;
            r_op     <= w_op;
            r_cnt    <= w_cnt;
            r_result <= w_result;
            r_err    <= w_err;
            r_valid  <= w_valid;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_a      = r_a;
        w_b      = r_b;
        w_op     = r_op;
        w_cnt    = r_cnt;
        w_result = r_result;
        w_err    = r_err;
        w_valid  = r_valid;
        // Abort wins over any byte arriving in the same cycle.
        if (i_clear) begin
            w_state  = S_A;
            w_a      = '0;
            w_b      = '0;
            w_op     = '0;
            w_cnt    = '0;
            w_result = '0;
            w_err    = 1'b0;
            w_valid  = 1'b0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_pulse) begin
                        w_a     = i_in_data;
                        w_state = S_B;
                    end
                end
                S_B: begin
                    if (w_pulse) begin
                        w_b     = i_in_data;
                        w_state = S_OP;
                    end
                end
                S_OP: begin
                    if (w_pulse) begin
                        w_op    = i_in_data[OP_W-1:0];
                        w_cnt   = CNT_W'(EXEC_LAT - 1);
                        w_state = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        w_result = dp.calc_result;
                        w_err    = dp.calc_err;
                        w_valid  = 1'b1;
                        w_state  = S_DONE;
                    end else begin
                        w_cnt = r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (w_pulse) begin
                        w_valid = 1'b0;
                        w_err   = 1'b0;
`ifdef CALC_SEQ_ACC_EN
                        w_a     = r_result;
                        w_b     = i_in_data;
                        w_state = S_OP;
`else
                        w_a     = i_in_data;
                        w_state = S_B;
`endif
                    end
                end
                default: w_state = S_A;
            endcase
        end
    end

    assign dp.calc_a      = r_a;
    assign dp.calc_b      = r_b;
    assign dp.calc_op     = r_op;
    assign o_result       = r_result;
    assign o_result_valid = r_valid;
    assign o_err          = r_err;
    assign o_busy         = (r_state == S_B) || (r_state == S_OP) || (r_state == S_EXEC);
    assign o_state        = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: one instance with EXEC_LAT=1, one with EXEC_LAT=4,
// each fed by a behavioural datapath (add / sub / xor, error on opcode 7).
module tb_calc_sequencer;
    import calc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       stb1, stb4, clear;
    logic [7:0] in_data;

    logic [7:0] res1, res4;
    logic       val1, val4, err1, err4, busy1, busy4;
    logic [2:0] st1, st4;

    int n_cmp = 0;
    int n_err = 0;

    calc_sequencer_if #(.DATA_W(8), .OP_W(3)) if1 ();
    calc_sequencer_if #(.DATA_W(8), .OP_W(3)) if4 ();

    function automatic logic [8:0] dp_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
        logic [7:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            default: r = a ^ b;
        endcase
        return {(op == 3'd7), r};
    endfunction

    assign {if1.calc_err, if1.calc_result} = dp_model(if1.calc_a, if1.calc_b, if1.calc_op);
    assign {if4.calc_err, if4.calc_result} = dp_model(if4.calc_a, if4.calc_b, if4.calc_op);

    calc_sequencer #(.DATA_W(8), .OP_W(3), .EXEC_LAT(1), .SYNC_STAGES(2)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_in_data      (in_data),
        .i_in_strobe    (stb1),
        .i_clear        (clear),
        .dp             (if1),
        .o_result       (res1),
        .o_result_valid (val1),
        .o_err          (err1),
        .o_busy         (busy1),
        .o_state        (st1)
    );

    calc_sequencer #(.DATA_W(8), .OP_W(3), .EXEC_LAT(4), .SYNC_STAGES(2)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_in_data      (in_data),
        .i_in_strobe    (stb4),
        .i_clear        (clear),
        .dp             (if4),
        .o_result       (res4),
        .o_result_valid (val4),
        .o_err          (err4),
        .o_busy         (busy4),
        .o_state        (st4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        logic       err;
    } vec_t;

    vec_t vt[6];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full strobe cycle: rise, wait for the synced pulse to be consumed, fall and settle.
    task automatic send(input bit sel4, input logic [7:0] d);
        in_data = d;
        if (sel4) stb4 = 1'b1;
        else      stb1 = 1'b1;
        tick(3);
        stb1 = 1'b0;
        stb4 = 1'b0;
        tick(3);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        vt[0] = '{a: 8'h12, b: 8'h34, op: 8'h00, res: 8'h46, err: 1'b0};
        vt[1] = '{a: 8'h80, b: 8'h90, op: 8'h00, res: 8'h10, err: 1'b0};
        vt[2] = '{a: 8'h05, b: 8'h07, op: 8'h01, res: 8'hFE, err: 1'b0};
        vt[3] = '{a: 8'h3C, b: 8'h0F, op: 8'h07, res: 8'h33, err: 1'b1};
        vt[4] = '{a: 8'hA5, b: 8'h5A, op: 8'hF9, res: 8'h4B, err: 1'b0};
        vt[5] = '{a: 8'hFF, b: 8'h01, op: 8'h00, res: 8'h00, err: 1'b0};

        rst_n = 1'b0; stb1 = 1'b0; stb4 = 1'b0; clear = 1'b0; in_data = 8'h00;

        // Reset with a toggling strobe, then release with the strobe held high.
        for (int i = 0; i < 3; i++) begin
            stb1 = ~stb1;
            stb4 = ~stb4;
            in_data = 8'hC3;
            tick(1);
        end
        check("rst_state", st1, 0);
        check("rst_state4", st4, 0);
        check("rst_result", res1, 0);
        check("rst_valid", val1, 0);
        check("rst_err", err1, 0);
        check("rst_busy", busy1, 0);
        check("rst_calc_a", if1.calc_a, 0);
        check("rst_calc_b", if1.calc_b, 0);
        check("rst_calc_op", if1.calc_op, 0);
        rst_n = 1'b1;
        tick(8);
        check("held_stb_no_pulse", st1, S_A);
        check("held_stb_no_pulse4", st4, S_A);
        check("held_stb_calc_a", if1.calc_a, 0);
        stb1 = 1'b0; stb4 = 1'b0;
        tick(4);

        // Table: full operations on the EXEC_LAT=1 instance.
        for (int i = 0; i < 6; i++) begin
            do_clear();
            send(1'b0, vt[i].a);
            send(1'b0, vt[i].b);
            in_data = vt[i].op;
            stb1 = 1'b1;
            tick(3);
            check($sformatf("v%0d_state_exec", i), st1, S_EXEC);
            check($sformatf("v%0d_busy_exec", i), busy1, 1);
            check($sformatf("v%0d_valid_early", i), val1, 0);
            check($sformatf("v%0d_calc_a", i), if1.calc_a, vt[i].a);
            check($sformatf("v%0d_calc_b", i), if1.calc_b, vt[i].b);
            tick(1);
            check($sformatf("v%0d_valid", i), val1, 1);
            check($sformatf("v%0d_result", i), res1, vt[i].res);
            check($sformatf("v%0d_err", i), err1, vt[i].err);
            check($sformatf("v%0d_busy_done", i), busy1, 0);
            check($sformatf("v%0d_state_done", i), st1, S_DONE);
            check($sformatf("v%0d_calc_op", i), if1.calc_op, 32'(vt[i].op & 8'h07));
            stb1 = 1'b0;
            tick(3);
        end

        // Strobe held high for 20 cycles in S_A loads exactly one byte.
        do_clear();
        in_data = 8'h55;
        stb1 = 1'b1;
        tick(20);
        check("held20_state", st1, S_B);
        check("held20_calc_a", if1.calc_a, 8'h55);
        check("held20_calc_b", if1.calc_b, 8'h00);
        stb1 = 1'b0;
        tick(3);

        // Clear coincident with a pulse in S_B: byte dropped, back to S_A.
        in_data = 8'h77;
        stb1 = 1'b1;
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_pulse_state", st1, S_A);
        check("clr_pulse_calc_b", if1.calc_b, 0);
        check("clr_pulse_calc_a", if1.calc_a, 0);
        check("clr_pulse_result", res1, 0);
        check("clr_pulse_valid", val1, 0);
        tick(4);
        check("clr_pulse_state_later", st1, S_A);
        stb1 = 1'b0;
        tick(3);

        // EXEC_LAT=4: error opcode, with a second strobe landing during execution.
        do_clear();
        send(1'b1, 8'h3C);
        send(1'b1, 8'h0F);
        in_data = 8'h07;
        stb4 = 1'b1;
        tick(1);
        stb4 = 1'b0;
        tick(1);
        stb4 = 1'b1;
        tick(1);
        in_data = 8'h99;
        check("x4_state_exec", st4, S_EXEC);
        tick(2);
        check("x4_state_after_extra", st4, S_EXEC);
        check("x4_calc_op_held", if4.calc_op, 3'd7);
        check("x4_calc_b_held", if4.calc_b, 8'h0F);
        tick(1);
        check("x4_valid_early", val4, 0);
        tick(1);
        check("x4_valid", val4, 1);
        check("x4_result", res4, 8'h33);
        check("x4_err", err4, 1);
        check("x4_state_done", st4, S_DONE);
        check("x4_calc_a_held", if4.calc_a, 8'h3C);
        stb4 = 1'b0;
        tick(3);

        // Clear during S_EXEC aborts before capture.
        do_clear();
        send(1'b1, 8'h10);
        send(1'b1, 8'h20);
        in_data = 8'h00;
        stb4 = 1'b1;
        tick(3);
        check("clr_exec_pre_state", st4, S_EXEC);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_exec_state", st4, S_A);
        check("clr_exec_result", res4, 0);
        check("clr_exec_valid", val4, 0);
        check("clr_exec_err", err4, 0);
        check("clr_exec_calc_a", if4.calc_a, 0);
        tick(6);
        check("clr_exec_valid_later", val4, 0);
        check("clr_exec_state_later", st4, S_A);
        stb4 = 1'b0;
        tick(3);

        // Byte arriving after completion.
        do_clear();
        send(1'b0, 8'h12);
        send(1'b0, 8'h34);
        send(1'b0, 8'h00);
        check("chain_base_result", res1, 8'h46);
        check("chain_base_valid", val1, 1);
        send(1'b0, 8'h01);
`ifdef CALC_SEQ_ACC_EN
        check("chain_state", st1, S_OP);
        check("chain_calc_a", if1.calc_a, 8'h46);
        check("chain_calc_b", if1.calc_b, 8'h01);
        check("chain_valid_cleared", val1, 0);
        send(1'b0, 8'h00);
        check("chain_valid", val1, 1);
        check("chain_result", res1, 8'h47);
`else
        check("chain_state", st1, S_B);
        check("chain_calc_a", if1.calc_a, 8'h01);
        check("chain_valid_cleared", val1, 0);
        check("chain_err_cleared", err1, 0);
        check("chain_busy", busy1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
